// File: rtl/tmds_channel_decoder.sv
// tmds_channel_decoder: TMDS word aligner and decoder for one channel; define TMDS_DEC_ERRCNT_EN to add lock_loss_cnt
module tmds_channel_decoder #(
  parameter int TOKEN_COUNT    = 8,
  parameter int SEARCH_TIMEOUT = 1024,
  parameter int LOSS_TIMEOUT   = 4096
)(
  input  logic       clk_pixel,
  input  logic       reset,
  input  logic [9:0] tmds_in,
  output logic [7:0] dout,
  output logic       c0,
  output logic       c1,
  output logic       de,
  output logic       locked,
  output logic [3:0] offset
`ifdef TMDS_DEC_ERRCNT_EN
  ,
  output logic [7:0] lock_loss_cnt
`endif
);
  localparam int TW = $clog2(TOKEN_COUNT) + 1;
  localparam int SW = $clog2(SEARCH_TIMEOUT) + 1;
  localparam int LW = $clog2(LOSS_TIMEOUT) + 1;
  typedef enum logic {SEARCH, LOCKED} state_t;
  state_t state, nxt;
  logic [9:0] r1, r2, aligned;
  logic [19:0] win;
  logic is_tok, hit, tout, lost, slip, de_n, c0_n, c1_n;
  logic [1:0] tok_c, flush;
  logic [7:0] q, dec, dout_n;
  logic [TW-1:0] tok_run, tok_run_n;
  logic [SW-1:0] timer, timer_n;
  logic [LW-1:0] gap, gap_n;
  assign win = {r1, r2} >> offset;
  // Two-word window of the raw stream and the word picked out at the current offset
  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      r1 <= '0;
      r2 <= '0;
      aligned <= '0;
    end else begin
      r1 <= tmds_in;
      r2 <= r1;
      aligned <= win[9:0];
    end
  end
  // Control token match and 10b->8b data decode of the aligned word
  always_comb begin
    is_tok = aligned == 10'b1101010100 || aligned == 10'b0010101011 ||
             aligned == 10'b0101010100 || aligned == 10'b1010101011;
    tok_c = aligned == 10'b0010101011 ? 2'b01 :
            aligned == 10'b0101010100 ? 2'b10 :
            aligned == 10'b1010101011 ? 2'b11 : 2'b00;
    q = aligned[7:0] ^ {8{aligned[9]}};
    dec = {q[7:1] ^ q[6:0] ^ {7{~aligned[8]}}, q[0]};
  end
  // Next state: lock beats a coincident search timeout; flush words leave everything frozen
  always_comb begin
    tok_run_n = is_tok ? tok_run + 1'b1 : '0;
    timer_n = timer + 1'b1;
    gap_n = is_tok ? '0 : gap + 1'b1;
    hit = tok_run_n == TW'(TOKEN_COUNT);
    tout = timer_n == SW'(SEARCH_TIMEOUT);
    lost = gap_n == LW'(LOSS_TIMEOUT);
    slip = state == SEARCH && flush == 2'd0 && !hit && tout;
    nxt = flush != 2'd0 ? state :
          state == SEARCH ? (hit ? LOCKED : SEARCH) : (lost ? SEARCH : LOCKED);
  end
  // Output values for the word being retired, based on the state it leaves us in
  always_comb begin
    de_n = nxt == LOCKED && !is_tok;
    dout_n = de_n ? dec : '0;
    c0_n = nxt != LOCKED ? 1'b0 : is_tok ? tok_c[0] : c0;
    c1_n = nxt != LOCKED ? 1'b0 : is_tok ? tok_c[1] : c1;
  end
  // State, counters, offset slipping and registered outputs
  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      state <= SEARCH;
      offset <= '0;
      tok_run <= '0;
      timer <= '0;
      gap <= '0;
      flush <= '0;
      dout <= '0;
      c0 <= 1'b0;
      c1 <= 1'b0;
      de <= 1'b0;
      locked <= 1'b0;
`ifdef TMDS_DEC_ERRCNT_EN
      lock_loss_cnt <= '0;
`endif
    end else begin
      state <= nxt;
      locked <= nxt == LOCKED;
      dout <= dout_n;
      de <= de_n;
      c0 <= c0_n;
      c1 <= c1_n;
      if (flush != 2'd0) begin
        flush <= flush - 2'd1;
      end else if (state == SEARCH) begin
        if (hit) begin
          gap <= '0;
          tok_run <= '0;
          timer <= '0;
        end else if (slip) begin
          offset <= offset == 4'd9 ? 4'd0 : offset + 4'd1;
          tok_run <= '0;
          timer <= '0;
          flush <= 2'd2;
        end else begin
          tok_run <= tok_run_n;
          timer <= timer_n;
        end
      end else if (lost) begin
        gap <= '0;
        tok_run <= '0;
        timer <= '0;
`ifdef TMDS_DEC_ERRCNT_EN
        lock_loss_cnt <= lock_loss_cnt + {7'd0, lock_loss_cnt != 8'hFF};
`endif
      end else begin
        gap <= gap_n;
      end
    end
  end
endmodule

// File: tb/tb_tmds_channel_decoder.sv
// tb_tmds_channel_decoder: scoreboard bench with a word-level reference model of alignment and decode
module tb_tmds_channel_decoder;
  localparam int TC = 8;
  localparam int ST = 1024;
  localparam int LT = 4096;
  localparam logic [9:0] TOK0 = 10'b1101010100;
  localparam logic [9:0] TOK1 = 10'b0010101011;
  localparam logic [9:0] TOK2 = 10'b0101010100;
  localparam logic [9:0] TOK3 = 10'b1010101011;
  logic clk_pixel = 1'b0;
  logic reset = 1'b1;
  logic [9:0] tmds_in = '0;
  logic [7:0] dout;
  logic c0, c1, de, locked;
  logic [3:0] offset;
  logic [7:0] lock_loss_cnt;
  always #5 clk_pixel = ~clk_pixel;
  tmds_channel_decoder dut (
    .clk_pixel(clk_pixel),
    .reset(reset),
    .tmds_in(tmds_in),
    .dout(dout),
    .c0(c0),
    .c1(c1),
    .de(de),
    .locked(locked),
    .offset(offset)
`ifdef TMDS_DEC_ERRCNT_EN
    ,
    .lock_loss_cnt(lock_loss_cnt)
`endif
  );
`ifndef TMDS_DEC_ERRCNT_EN
  assign lock_loss_cnt = '0;
`endif
  typedef struct packed {
    logic [7:0] dout;
    logic c0, c1, de, locked;
    logic [3:0] offset;
    logic [7:0] llc;
  } exp_t;
  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  logic [9:0] m_r1, m_r2, m_al, prev_tx;
  int m_off, m_run, m_tmr, m_gap, m_flush, m_llc, phase;
  bit m_lock, m_c0, m_c1;
  logic [9:0] toks [4];
  initial begin
    toks[0] = TOK0;
    toks[1] = TOK1;
    toks[2] = TOK2;
    toks[3] = TOK3;
  end
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  function automatic int tok_code(input logic [9:0] w);
    case (w)
      TOK0: return 0;
      TOK1: return 1;
      TOK2: return 2;
      TOK3: return 3;
      default: return -1;
    endcase
  endfunction
  function automatic logic [7:0] ref_dec(input logic [9:0] w);
    logic [7:0] b, d;
    b = w[9] ? ~w[7:0] : w[7:0];
    d[0] = b[0];
    for (int i = 1; i < 8; i++) d[i] = w[8] ? b[i] ^ b[i-1] : ~(b[i] ^ b[i-1]);
    return d;
  endfunction
  // One clock of the reference: decide on the word already aligned, then form the next one
  task automatic model_step(input logic [9:0] cap);
    exp_t e;
    int t;
    logic [19:0] wv;
    t = tok_code(m_al);
    e = '0;
    if (m_flush > 0) m_flush--;
    else if (!m_lock) begin
      m_run = t >= 0 ? m_run + 1 : 0;
      m_tmr++;
      if (m_run == TC) begin
        m_lock = 1;
        m_gap = 0;
      end else if (m_tmr == ST) begin
        m_off = (m_off + 1) % 10;
        m_run = 0;
        m_tmr = 0;
        m_flush = 2;
      end
    end else begin
      m_gap = t >= 0 ? 0 : m_gap + 1;
      if (m_gap == LT) begin
        m_lock = 0;
        m_run = 0;
        m_tmr = 0;
        if (m_llc < 255) m_llc++;
      end
    end
    if (!m_lock) begin
      m_c0 = 0;
      m_c1 = 0;
    end else if (t >= 0) begin
      m_c0 = (t % 2) == 1;
      m_c1 = t >= 2;
    end else begin
      e.de = 1'b1;
      e.dout = ref_dec(m_al);
    end
    e.c0 = m_c0;
    e.c1 = m_c1;
    e.locked = m_lock;
    e.offset = 4'(m_off);
`ifdef TMDS_DEC_ERRCNT_EN
    e.llc = 8'(m_llc);
`endif
    wv = {m_r1, m_r2} >> m_off;
    m_al = wv[9:0];
    m_r2 = m_r1;
    m_r1 = cap;
    sb.push_back(e);
  endtask
  // Transmit one word; phase sets where the word boundary falls inside captured words
  task automatic send(input logic [9:0] w);
    logic [19:0] sh;
    sh = {w, prev_tx} >> (10 - phase);
    prev_tx = w;
    reset = 1'b0;
    tmds_in = sh[9:0];
    model_step(sh[9:0]);
    @(posedge clk_pixel);
    #1;
  endtask
  task automatic do_rst(input int k);
    exp_t e;
    e = '0;
    if (m_lock == 0) m_llc = m_llc;
    m_r1 = '0;
    m_r2 = '0;
    m_al = '0;
    m_off = 0;
    m_run = 0;
    m_tmr = 0;
    m_gap = 0;
    m_flush = 0;
    m_llc = 0;
    m_lock = 0;
    m_c0 = 0;
    m_c1 = 0;
    prev_tx = '0;
    phase = k;
    reset = 1'b1;
    tmds_in = '0;
    sb.push_back(e);
    @(posedge clk_pixel);
    #1;
    reset = 1'b0;
  endtask
  // Monitor: every output cycle is compared against the oldest expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_pixel);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("dout", dout, e.dout);
        chk("c0", c0, e.c0);
        chk("c1", c1, e.c1);
        chk("de", de, e.de);
        chk("locked", locked, e.locked);
        chk("offset", offset, e.offset);
`ifdef TMDS_DEC_ERRCNT_EN
        chk("lock_loss_cnt", lock_loss_cnt, e.llc);
`endif
      end
    end
  end
  initial begin
    do_rst(0);
    chk("rst_locked", locked, 0);
    chk("rst_offset", offset, 0);
    repeat (12) send(TOK2);
    chk("aligned_locked", locked, 1);
    chk("aligned_offset", offset, 0);
    chk("aligned_c1", c1, 1);
    chk("aligned_c0", c0, 0);
    chk("aligned_de", de, 0);
    send(10'h100);
    send(10'h3FF);
    send(10'h0FF);
    chk("data_hold_c1", c1, 1);
    repeat (200) begin
      if ($urandom_range(0, 3) == 0) send(toks[$urandom_range(0, 3)]);
      else send(10'($urandom_range(0, 1023)));
    end
    send(TOK1);
    repeat (LT + 5) send(10'h100);
    chk("loss_locked", locked, 0);
    chk("loss_offset", offset, 0);
`ifdef TMDS_DEC_ERRCNT_EN
    chk("loss_cnt", lock_loss_cnt, 1);
`endif
    do_rst(0);
    repeat (ST - 11) send(10'h100);
    repeat (8) send(TOK3);
    repeat (4) send(TOK3);
    chk("simul_locked", locked, 1);
    chk("simul_offset", offset, 0);
    chk("simul_c0", c0, 1);
    chk("simul_c1", c1, 1);
    do_rst(7);
    repeat (7 * (ST + 2) + 40) send(TOK2);
    chk("mis_locked", locked, 1);
    chk("mis_offset", offset, 7);
    chk("mis_c1", c1, 1);
    do_rst(5);
    repeat (5 * (ST + 2) + 40) send(TOK2);
    chk("pre_rst_locked", locked, 1);
    chk("pre_rst_offset", offset, 5);
    repeat (3) send(10'h0FF);
    do_rst(5);
    chk("midrst_locked", locked, 0);
    chk("midrst_offset", offset, 0);
    chk("midrst_de", de, 0);
    chk("midrst_dout", dout, 0);
    chk("midrst_c0", c0, 0);
    chk("midrst_c1", c1, 0);
    repeat (4) send(TOK0);
    @(negedge clk_pixel);
    #1;
    chk("queue_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
